prog_loader: RTL and testbench

Boot-time program loader for the single-cycle CPU: the write side of the instruction memory, which the CPU core only reads. It accepts a framed byte stream (16-bit length, little-endian instruction words, XOR checksum), packs bytes into 32-bit words and writes them into instruction memory. It holds the CPU's `pc` in reset until the image is fully loaded and verified.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader_word_packer.sv | 36 +++
 rtl/prog_loader.sv | 101 ++++++++++
 tb/tb_prog_loader.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  import loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_byte;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles four little-endian bytes into one 32-bit word.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0] lane;

  // full marks the push that completes a word, so the FSM can leave DATA on that edge
  assign full = push && (lane == 2'd3);

  // Shifting right leaves the first byte in the low lane after four pushes
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane <= '0;
      word <= '0;
    end else begin
      if (clear) begin
        lane <= '0;
      end else if (push) begin
        lane <= lane + 2'd1;
      end
      if (push) begin
        word <= {data, word[WORD_W-1:BYTE_W]};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed, checksummed image into instruction memory and holds the CPU in reset until it is verified.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error,
  output logic [15:0]  words_loaded
);

  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

  state_t            state;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              full;
  logic [15:0]       hdr_len;

  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;
  assign hdr_len      = {bus.in_byte, len[7:0]};

  assign bus.im_we    = (state == WRITE);
  assign bus.im_addr  = addr;
  assign cpu_hold     = (state != DONE);
  assign done         = (state == DONE);
  assign error        = (state == ERR);

  word_packer u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (state != DATA),
    .push  (accept && (state == DATA)),
    .data  (bus.in_byte),
    .word  (bus.im_wdata),
    .full  (full)
  );

  // The checksum byte itself is excluded from the running XOR
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LEN_LO;
      len          <= '0;
      csum         <= '0;
      addr         <= BASE_ADDR;
      words_loaded <= '0;
    end else begin
      if (accept && (state != CSUM)) begin
        csum <= csum ^ bus.in_byte;
      end
      case (state)
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.in_byte;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len <= hdr_len;
            if ({1'b0, hdr_len} > DEPTH_LIMIT) begin
              state <= ERR;
            end else if (hdr_len == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (full) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          addr         <= addr + ADDR_W'(4);
          state        <= (words_loaded + 16'd1 == len) ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) begin
            state <= (bus.in_byte == csum) ? DONE : ERR;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: writes are predicted into a queue and checked as im_we pulses appear.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_0100;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest predicted {addr, data} and find the input stalled
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      logic [63:0] e;
      checkOutput("ready_in_write", 64'(bus.in_ready), 64'd0);
      checkOutput("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("write_addr_data", {bus.im_addr, bus.im_wdata}, e);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit stall);
    int budget;
    @(negedge clk);
    if (stall) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("ready_timeout", 64'(budget < 50), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input bit bad, input bit stall);
    logic [15:0] n;
    logic [7:0]  x;
    logic [31:0] w;
    n = 16'(img.size());
    x = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({BASE + 32'(4 * i), img[i]});
    end
    applyStimulus(n[7:0], stall);
    x ^= n[7:0];
    applyStimulus(n[15:8], stall);
    x ^= n[15:8];
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        applyStimulus(w[8*k +: 8], stall);
        x ^= w[8*k +: 8];
      end
    end
    applyStimulus(bad ? (x ^ 8'h12) : x, stall);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_im_we", 64'(bus.im_we), 64'd0);
    checkOutput("rst_im_addr", 64'(bus.im_addr), 64'(BASE));
    checkOutput("rst_im_wdata", 64'(bus.im_wdata), 64'd0);
    checkOutput("rst_status", {61'd0, cpu_hold, done, error}, 64'b100);
    checkOutput("rst_words", 64'(words_loaded), 64'd0);
    checkOutput("rst_queue_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b1;
  endtask

  task automatic checkStatus(input string tag, input logic d, input logic e, input logic [15:0] wl);
    checkOutput({tag, "_status"}, {61'd0, cpu_hold, done, error}, {61'd0, ~d, d, e});
    checkOutput({tag, "_words"}, 64'(words_loaded), 64'(wl));
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    $display("[TB] nominal two-word load");
    doReset();
    img = '{32'h0000_0013, 32'h0010_0093};
    sendFrame(1'b0, 1'b0);
    checkStatus("nominal", 1'b1, 1'b0, 16'd2);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h5A;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    checkStatus("done_ignores_bytes", 1'b1, 1'b0, 16'd2);

    $display("[TB] empty image");
    doReset();
    img = {};
    sendFrame(1'b0, 1'b0);
    checkStatus("empty", 1'b1, 1'b0, 16'd0);

    $display("[TB] length overflow");
    doReset();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkStatus("overflow", 1'b0, 1'b1, 16'd0);
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    checkStatus("err_sticky", 1'b0, 1'b1, 16'd0);

    $display("[TB] bad checksum");
    doReset();
    img = '{32'h0000_0013, 32'h0010_0093};
    sendFrame(1'b1, 1'b0);
    checkStatus("bad_csum", 1'b0, 1'b1, 16'd2);

    $display("[TB] stalled stream");
    doReset();
    img = '{32'h0000_0013, 32'h0010_0093, 32'hA5C3_0F81};
    sendFrame(1'b0, 1'b1);
    checkStatus("stall", 1'b1, 1'b0, 16'd3);

    $display("[TB] reset mid-frame");
    doReset();
    exp_q.push_back({BASE, 32'h0000_0013});
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h13, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    doReset();
    img = '{32'hCAFE_F00D};
    sendFrame(1'b0, 1'b0);
    checkStatus("reload", 1'b1, 1'b0, 16'd1);

    $display("[TB] full-depth image");
    doReset();
    img = {};
    for (int i = 0; i < int'(DEPTH); i++) begin
      img.push_back($urandom());
    end
    sendFrame(1'b0, 1'b0);
    checkStatus("full_depth", 1'b1, 1'b0, 16'(DEPTH));

    repeat (3) @(negedge clk);
    checkOutput("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
